// File: rtl/wordline_sequencer_pkg.sv
// Shared definitions for the wordline sequencer: FSM state encoding and parameter defaults.
// The ADDR_WIDTH default follows the codebase-wide ADDR_WIDTH define, falling back to 4.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package wordline_sequencer_pkg;

   localparam int unsigned DEF_ADDR_WIDTH       = `ADDR_WIDTH;
   localparam int unsigned DEF_ROWS             = 1 << DEF_ADDR_WIDTH;
   localparam int unsigned DEF_PRECHARGE_CYCLES = 1;
   localparam int unsigned DEF_PULSE_CYCLES     = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_ACT  = 2'd2,
      ST_ERR  = 2'd3
   } wl_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/wordline_sequencer_onehot_decode.sv
// Combinational row-address to one-hot decoder with enable and in-range flag.
module onehot_decode #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned ROWS       = 16
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  en,
   output logic [ROWS-1:0]       onehot_c,
   output logic                  in_range_c
);

   assign in_range_c = ({1'b0, addr} < (ADDR_WIDTH+1)'(ROWS));

   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         onehot_c[i] = en && (addr == ADDR_WIDTH'(i));
      end
   end

endmodule

// File: rtl/wordline_sequencer.sv
// Registered wordline sequencer: handshake, precharge phase, one-hot wordline pulse, done/err.
// Optional build macro WORDLINE_REFRESH_EN adds a refresh_req/refresh_ack path with a row counter.
module wordline_sequencer
   import wordline_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
   parameter int unsigned ROWS             = 1 << ADDR_WIDTH,
   parameter int unsigned PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES,
   parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef WORDLINE_REFRESH_EN
   input  logic                  refresh_req,
   output logic                  refresh_ack,
`endif
   output logic                  req_ready,
   output logic                  precharge,
   output logic [ROWS-1:0]       wl,
   output logic                  done,
   output logic                  err,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(max_u(PRECHARGE_CYCLES, PULSE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(PULSE_CYCLES - 1);

   wl_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  precharge_q, precharge_d;
   logic [ROWS-1:0]       wl_q, wl_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;

   logic [ADDR_WIDTH-1:0] dec_addr;
   logic                  dec_en;
   logic [ROWS-1:0]       dec_onehot;
   logic                  dec_in_range;
   logic                  refresh_go;
   logic [ADDR_WIDTH-1:0] refresh_row;
   logic                  refresh_active;

`ifdef WORDLINE_REFRESH_EN
   logic [ADDR_WIDTH-1:0] ref_row_q, ref_row_d;
   logic                  is_ref_q, is_ref_d;
   logic                  refresh_ack_q, refresh_ack_d;

   assign refresh_go     = refresh_req;
   assign refresh_row    = ref_row_q;
   assign refresh_active = is_ref_d;
   assign refresh_ack    = refresh_ack_q;

   // Refresh bookkeeping: tag the access and advance the row counter when it completes.
   always_comb begin
      is_ref_d  = is_ref_q;
      ref_row_d = ref_row_q;
      if (state_q == ST_IDLE) begin
         is_ref_d = refresh_req;
      end
      if ((state_q == ST_ACT) && (cnt_q == ACT_LAST) && is_ref_q) begin
         ref_row_d = (ref_row_q == ADDR_WIDTH'(ROWS - 1)) ? '0 : ref_row_q + ADDR_WIDTH'(1);
      end
      refresh_ack_d = (state_d == ST_ACT) && (cnt_d == ACT_LAST) && is_ref_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_row_q     <= '0;
         is_ref_q      <= 1'b0;
         refresh_ack_q <= 1'b0;
      end else begin
         ref_row_q     <= ref_row_d;
         is_ref_q      <= is_ref_d;
         refresh_ack_q <= refresh_ack_d;
      end
   end
`else
   assign refresh_go     = 1'b0;
   assign refresh_row    = '0;
   assign refresh_active = 1'b0;
`endif

   assign req_ready = (state_q == ST_IDLE) && !refresh_go;

   // Range check on the incoming address while idle, decode of the latched row otherwise.
   assign dec_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
   assign dec_en   = (state_d == ST_ACT);

   onehot_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ROWS       (ROWS)
   ) u_decode (
      .addr       (dec_addr),
      .en         (dec_en),
      .onehot_c   (dec_onehot),
      .in_range_c (dec_in_range)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (refresh_go) begin
               state_d = ST_PRE;
               cnt_d   = '0;
               addr_d  = refresh_row;
            end else if (req_valid) begin
               cnt_d = '0;
               if (dec_in_range) begin
                  state_d = ST_PRE;
                  addr_d  = req_addr;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = ST_ACT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ACT: begin
            if (cnt_q == ACT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      precharge_d = (state_d == ST_PRE);
      wl_d        = dec_onehot;
      done_d      = (state_d == ST_ACT) && (cnt_d == ACT_LAST) && !refresh_active;
      err_d       = (state_d == ST_ERR);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         precharge_q <= 1'b0;
         wl_q        <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         precharge_q <= precharge_d;
         wl_q        <= wl_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign precharge = precharge_q;
   assign wl        = wl_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule
